// File: rtl/instr_mem_resp.sv
// Multi-cycle instruction-memory responder: one rd/wr access at a time, done after LATENCY cycles.
// Optional macro IMEM_ALIGN_CHECK_EN: odd byte addresses complete at once with err and no access.
module instr_mem_resp #(
    parameter int DEPTH_LOG2 = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    // Handshake: a request (rd|wr) seen in IDLE is accepted that cycle; stall stays high
    // until the RESP cycle, where done pulses once. The requester holds its inputs while
    // stall is high and may drop or change them from the done cycle onwards.

    logic [15:0]           r_mem [DEPTH];
    state_t                r_state;
    state_t                w_next;
    logic [3:0]            r_cnt;
    logic [3:0]            w_cnt_next;
    logic [DEPTH_LOG2-1:0] r_idx;
    logic [15:0]           r_wdata;
    logic                  r_is_rd;
    logic                  r_is_wr;
    logic                  r_err;
    logic [15:0]           r_dout;

    logic                  w_req;
    logic                  w_accept;
    logic                  w_misalign;
    logic                  w_bad;
    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_unused_addr;

    assign w_idx         = addr[DEPTH_LOG2:1];
    assign w_unused_addr = ^{addr[15:DEPTH_LOG2+1], addr[0]};
    assign w_req         = rd | wr;
    assign w_accept      = (r_state == IDLE) & w_req;

`ifdef IMEM_ALIGN_CHECK_EN
    assign w_misalign = addr[0];
`else
    assign w_misalign = 1'b0;
`endif

    assign w_bad = (rd & wr) | w_misalign;

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_cnt_next = LAT_M1;
                    if (w_misalign || (LATENCY == 1)) begin
                        w_next     = RESP;
                        w_cnt_next = 4'd0;
                    end else begin
                        w_next = BUSY;
                    end
                end
            end
            BUSY: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt <= 4'd1) begin
                    w_next     = RESP;
                    w_cnt_next = 4'd0;
                end
            end
            RESP: begin
                w_next     = IDLE;
                w_cnt_next = 4'd0;
            end
            default: begin
                w_next     = IDLE;
                w_cnt_next = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
            r_idx   <= '0;
            r_wdata <= 16'd0;
            r_is_rd <= 1'b0;
            r_is_wr <= 1'b0;
            r_err   <= 1'b0;
            r_dout  <= 16'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_wdata <= data_in;
                r_is_rd <= rd & ~wr & ~w_misalign;
                r_is_wr <= wr & ~rd & ~w_misalign;
                r_err   <= w_bad;
            end
            // Hold the last read word once the done cycle is over.
            if ((r_state == RESP) && r_is_rd) begin
                r_dout <= r_mem[r_idx];
            end
        end
    end

    // Storage is deliberately left out of reset so preloaded images survive rst.
    always_ff @(posedge clk) begin
        if (!rst && (r_state == RESP) && r_is_wr) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign done      = (r_state == RESP);
    assign err       = done & r_err;
    assign stall     = (r_state == BUSY) | w_accept;
    assign data_out  = (done & r_is_rd) ? r_mem[r_idx] : r_dout;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_instr_mem_resp.sv
// Directed bench for instr_mem_resp: one LATENCY=4 instance and one LATENCY=1 instance.
// Checks latency, stall, err, read data and reset-abort against hand-computed values.
module tb_instr_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd, wr;
    logic [15:0] addr, data_in, data_out;
    logic        done, stall, err;
    logic [1:0]  dbg_state;
    logic        rd1, wr1;
    logic [15:0] addr1, data_in1, data_out1;
    logic        done1, stall1, err1;
    logic [1:0]  dbg_state1;

    int          n_total = 0;
    int          n_bad   = 0;
    int          done_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] t4_exp;

    always #5 clk = ~clk;

    instr_mem_resp #(.DEPTH_LOG2(10), .LATENCY(4)) u_dut (
        .clk(clk), .rst(rst), .rd(rd), .wr(wr), .addr(addr), .data_in(data_in),
        .data_out(data_out), .done(done), .stall(stall), .err(err), .dbg_state(dbg_state)
    );

    instr_mem_resp #(.DEPTH_LOG2(10), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst(rst), .rd(rd1), .wr(wr1), .addr(addr1), .data_in(data_in1),
        .data_out(data_out1), .done(done1), .stall(stall1), .err(err1), .dbg_state(dbg_state1)
    );

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 of the request cycle; returns at posedge+3 of the done cycle.
    task automatic wait_done(input bit sel1, output int n, output int slo);
        n   = 0;
        slo = 0;
        #2;
        while (!(sel1 ? done1 : done) && n < 40) begin
            if (!(sel1 ? stall1 : stall)) slo++;
            @(posedge clk);
            #3;
            n++;
        end
        check("done_seen", {31'd0, (sel1 ? done1 : done)}, 32'd1);
    endtask

    task automatic access(input bit sel1, input logic r, input logic w,
                          input logic [15:0] a, input logic [15:0] d,
                          input int exp_n, input logic exp_err,
                          input logic [15:0] exp_do, input string tag);
        int n, slo;
        if (sel1) begin
            rd1 = r; wr1 = w; addr1 = a; data_in1 = d;
        end else begin
            rd = r; wr = w; addr = a; data_in = d;
        end
        wait_done(sel1, n, slo);
        check({tag, "_lat"},   n, exp_n);
        check({tag, "_stall_early"}, slo, 0);
        check({tag, "_stall_resp"}, {31'd0, (sel1 ? stall1 : stall)}, 32'd0);
        check({tag, "_state"}, {30'd0, (sel1 ? dbg_state1 : dbg_state)}, 32'd2);
        check({tag, "_err"},   {31'd0, (sel1 ? err1 : err)}, {31'd0, exp_err});
        check({tag, "_dout"},  {16'd0, (sel1 ? data_out1 : data_out)}, {16'd0, exp_do});
        if (sel1) begin
            rd1 = 1'b0; wr1 = 1'b0;
        end else begin
            rd = 1'b0; wr = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, slo, dc0;
        rst = 1'b1;
        rd = 1'b0; wr = 1'b0; addr = 16'd0; data_in = 16'd0;
        rd1 = 1'b0; wr1 = 1'b0; addr1 = 16'd0; data_in1 = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #2;
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_err",   {31'd0, err},   32'd0);
        check("rst_dout",  {16'd0, data_out}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_dout1", {16'd0, data_out1}, 32'd0);
        @(posedge clk);
        #1;

        // write then read back
        access(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 4, 1'b0, 16'h0000, "t1_wr");
        access(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 4, 1'b0, 16'hBEEF, "t1_rd");

        // held rd with address stepped at each done: one access per 5 cycles
        access(0, 1'b0, 1'b1, 16'h0000, 16'h1111, 4, 1'b0, 16'hBEEF, "t2_wr0");
        access(0, 1'b0, 1'b1, 16'h0002, 16'h2222, 4, 1'b0, 16'hBEEF, "t2_wr2");
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        rd = 1'b1; addr = 16'h0000;
        wait_done(0, n, slo);
        check("t2_lat0", n, 4);
        check("t2_slo0", slo, 0);
        check("t2_d0", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
        addr = 16'h0002;
        @(posedge clk);
        #1;
        wait_done(0, n, slo);
        check("t2_period", n + 1, 5);
        check("t2_slo1", slo, 0);
        check("t2_d1", {16'd0, data_out}, {16'd0, exp_q.pop_front()});
        rd = 1'b0;
        @(posedge clk);
        #1;

        // rd and wr together: error, no access
        access(0, 1'b0, 1'b1, 16'h0004, 16'h1234, 4, 1'b0, 16'h2222, "t3_wr");
        access(0, 1'b1, 1'b1, 16'h0004, 16'hFFFF, 4, 1'b1, 16'h2222, "t3_both");
        access(0, 1'b1, 1'b0, 16'h0004, 16'h0000, 4, 1'b0, 16'h1234, "t3_rd");

        // odd, out-of-range address
`ifdef IMEM_ALIGN_CHECK_EN
        t4_exp = 16'h1234;
        access(0, 1'b1, 1'b0, 16'h0811, 16'h0000, 1, 1'b1, t4_exp, "t4_mis");
`else
        t4_exp = 16'hBEEF;
        access(0, 1'b1, 1'b0, 16'h0811, 16'h0000, 4, 1'b0, t4_exp, "t4_alias");
`endif

        // reset in the middle of a write
        access(0, 1'b0, 1'b1, 16'h0020, 16'h5555, 4, 1'b0, t4_exp, "t5_pre");
        dc0 = done_cnt;
        wr = 1'b1; addr = 16'h0020; data_in = 16'hCAFE;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        wr  = 1'b0;
        #2;
        check("t5_stall", {31'd0, stall}, 32'd0);
        check("t5_state", {30'd0, dbg_state}, 32'd0);
        check("t5_dout",  {16'd0, data_out}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        check("t5_nodone", done_cnt - dc0, 0);
        access(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 4, 1'b0, 16'h5555, "t5_rd");

        // LATENCY=1 instance
        access(1, 1'b0, 1'b1, 16'h0010, 16'hA5A5, 1, 1'b0, 16'h0000, "t6_wr");
        rd1 = 1'b1; addr1 = 16'h0010;
        wait_done(1, n, slo);
        check("t6_lat0", n, 1);
        check("t6_slo0", slo, 0);
        check("t6_stall_resp", {31'd0, stall1}, 32'd0);
        check("t6_d0", {16'd0, data_out1}, 32'h0000A5A5);
        @(posedge clk);
        #1;
        wait_done(1, n, slo);
        check("t6_lat1", n, 1);
        check("t6_d1", {16'd0, data_out1}, 32'h0000A5A5);
        rd1 = 1'b0;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
